ingress_packet_buffer: RTL and testbench
========================================

Name: ingress_packet_buffer

Overview:
Ingress FIFO that sits directly upstream of packet_processing_pipeline and feeds its packet_in_valid/packet_in_data/packet_in_ready interface. It accepts 512-bit packet beats from the MAC side and applies whole-packet admission control, so an admitted packet can never overflow the buffer. It truncates oversize packets and keeps saturating drop/accept statistics.

Parameters:
DEPTH, 64, buffer depth in beats; power of 2, at least 4
DATA_WIDTH, 512, beat width in bits
MAX_PKT_BEATS, 16, maximum beats per packet; must be at most DEPTH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  ingress enable; the output side drains regardless
in_valid  in  1  input beat valid
in_data  in  DATA_WIDTH  input beat
in_last  in  1  final beat of packet
in_ready  out  1  input ready; equals enable
out_valid  out  1  buffered beat available
out_data  out  DATA_WIDTH  head beat
out_last  out  1  head beat ends a packet
out_err  out  1  head beat ends a truncated packet
out_ready  in  1  downstream ready (pipeline packet_in_ready)
stats_clear  in  1  synchronous clear of the statistics counters
occupancy  out  $clog2(DEPTH)+1  beats stored
high_water  out  $clog2(DEPTH)+1  peak occupancy since reset or clear
rx_packets  out  32  admitted packets, saturating
dropped_packets  out  32  dropped packets, saturating
trunc_packets  out  32  truncated packets, saturating

Behaviour:
- Reset (async, rst_n=0):
  - ptrs=0, state=IDLE, memory contents discarded.
  - out_valid=0, out_last=0, out_err=0, out_data=0.
  - occupancy=0, high_water=0, all counters=0.
- Reset mid-packet abandons the partial packet; nothing is counted for it.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Storage: show-ahead FIFO. out_data, out_last and out_err are a combinational read of mem[rd_ptr]; outputs are 0 when empty.
  - A beat written at edge N is presentable at N+1; latency is 1 cycle when empty.
- out_valid = (occupancy != 0). Data must stay stable while out_valid && !out_ready.
- free = DEPTH - occupancy, sampled before this cycle's read; this is conservative.
- State machine, evaluated only on input transfers:
  - IDLE (first beat): if free >= MAX_PKT_BEATS, write the beat and set beat_cnt=1.
    - If in_last: rx_packets+1, stay IDLE. Otherwise go to ACCEPT.
  - IDLE: if free < MAX_PKT_BEATS, discard the beat. If in_last: dropped_packets+1, stay IDLE. Otherwise go to DROP.
  - ACCEPT, beat_cnt < MAX_PKT_BEATS-1: write the beat, beat_cnt+1. If in_last: rx_packets+1, go to IDLE.
  - ACCEPT, beat_cnt == MAX_PKT_BEATS-1: write the beat with last=1.
    - If in_last: err=0, rx_packets+1, go to IDLE.
    - Otherwise: err=1, rx_packets+1, trunc_packets+1, go to TRUNC.
  - DROP: discard beats; on in_last, dropped_packets+1 and go to IDLE.
  - TRUNC: discard beats; on in_last, go to IDLE.
- Stored err bit is 0 on every beat except a truncation point.
- Simultaneous write and read: occupancy unchanged; both pointers advance.
- Pointers wrap modulo DEPTH; one extra occupancy bit distinguishes full from empty.
- Admission guarantees no write is attempted when full.
- high_water <= max(high_water, next occupancy) every cycle.
- Counters saturate at 32'hFFFF_FFFF.
- stats_clear:
  - Zeroes rx_packets, dropped_packets and trunc_packets; sets high_water to the current occupancy.
  - A counter event in the same cycle is lost (clear wins).
  - Does not touch the FIFO or the state.
- enable=0 mid-packet: in_ready=0, state and beat_cnt held; the packet resumes when enable returns.
- enable does not gate the output side.

Test Plan:
- Single 3-beat packet, out_ready=1 -> first out_valid one cycle after the first write. out_last only on beat 3. rx_packets=1, occupancy returns to 0.
- out_ready=0, four 16-beat packets (DEPTH=64) -> first three admitted (free 64/48/32). Fourth arrives with free=16 and is admitted; occupancy=64, high_water=64. A fifth packet is dropped entirely: dropped_packets=1, in_ready stays 1.
- 20-beat packet -> 16 beats stored, beat 16 has out_last=1 and out_err=1, beats 17-20 discarded. trunc_packets=1, rx_packets=1, occupancy=16.
- Continuous input and output at full rate for 200 beats across pointer wrap -> data order preserved and occupancy constant at 1. Check DEPTH=4 with MAX_PKT_BEATS=4.
- rst_n pulsed low during beat 5 of an 8-beat packet -> out_valid=0 immediately and all counters 0. The next packet is admitted from IDLE.
- stats_clear in the same cycle as a final beat -> rx_packets=0 afterwards; enable toggled low mid-packet holds in_ready=0 with no beats lost.

Source files
------------

// File: rtl/ingress_packet_buffer.sv
// Ingress packet buffer: show-ahead beat FIFO with whole-packet admission,
// oversize truncation and saturating accept/drop/truncate statistics.
module ingress_packet_buffer #(
  parameter int DEPTH         = 64,
  parameter int DATA_WIDTH    = 512,
  parameter int MAX_PKT_BEATS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    out_err,
  input  logic                    out_ready,
  input  logic                    stats_clear,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [$clog2(DEPTH):0]  high_water,
  output logic [31:0]             rx_packets,
  output logic [31:0]             dropped_packets,
  output logic [31:0]             trunc_packets
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_PKT_BEATS + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_PKT_BEATS);
  localparam logic [BW-1:0] LAST_IDX = BW'(MAX_PKT_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, DROP, TRUNC} state_e;

  typedef struct packed {
    logic                  err;
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t          mem [DEPTH];

  state_e         state_q, state_d;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  occ_q, occ_d;
  logic [CW-1:0]  hw_q, hw_d;
  logic [31:0]    rx_q, drop_q, trunc_q;

  logic           in_xfer, rd_en, wr_en, admit;
  logic           rx_inc, drop_inc, trunc_inc;
  logic [CW-1:0]  free;
  beat_t          wr_beat, head;

  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic inc);
    return (inc && (c != 32'hFFFF_FFFF)) ? c + 32'd1 : c;
  endfunction

  assign in_ready  = enable;
  assign in_xfer   = in_valid && enable;
  assign out_valid = (occ_q != '0);
  assign rd_en     = out_valid && out_ready;

  // Free space is taken before this cycle's read, so admission is conservative.
  assign free  = DEPTH_C - occ_q;
  assign admit = (free >= MAX_C);

  // Show-ahead head of the FIFO, forced to zero while empty.
  assign head     = out_valid ? mem[rd_ptr_q] : '0;
  assign out_data = head.data;
  assign out_last = head.last;
  assign out_err  = head.err;

  assign occupancy       = occ_q;
  assign high_water      = hw_q;
  assign rx_packets      = rx_q;
  assign dropped_packets = drop_q;
  assign trunc_packets   = trunc_q;

  // Packet admission / truncation decision for the beat offered this cycle.
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    wr_en      = 1'b0;
    wr_beat    = '{err: 1'b0, last: in_last, data: in_data};
    rx_inc     = 1'b0;
    drop_inc   = 1'b0;
    trunc_inc  = 1'b0;
    if (in_xfer) begin
      unique case (state_q)
        IDLE, ACCEPT: begin
          // beat_cnt is 0 in IDLE, so the first beat shares the ACCEPT path.
          if (state_q == ACCEPT || admit) begin
            wr_en = 1'b1;
            if (beat_cnt_q == LAST_IDX) begin
              wr_beat.last = 1'b1;
              wr_beat.err  = !in_last;
              rx_inc       = 1'b1;
              trunc_inc    = !in_last;
              beat_cnt_d   = '0;
              state_d      = in_last ? IDLE : TRUNC;
            end else if (in_last) begin
              rx_inc     = 1'b1;
              beat_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              beat_cnt_d = beat_cnt_q + BW'(1);
              state_d    = ACCEPT;
            end
          end else begin
            drop_inc = in_last;
            state_d  = in_last ? IDLE : DROP;
          end
        end
        DROP: begin
          if (in_last) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end
        end
        TRUNC: begin
          if (in_last) state_d = IDLE;
        end
      endcase
    end
  end

  // Occupancy bookkeeping and high-water tracking.
  always_comb begin
    occ_d = occ_q + CW'(wr_en) - CW'(rd_en);
    if (stats_clear) hw_d = occ_q;
    else             hw_d = (occ_d > hw_q) ? occ_d : hw_q;
  end

  // FSM, pointers, occupancy and saturating statistics.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      hw_q       <= '0;
      rx_q       <= '0;
      drop_q     <= '0;
      trunc_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_d;
      hw_q  <= hw_d;
      if (stats_clear) begin
        rx_q    <= '0;
        drop_q  <= '0;
        trunc_q <= '0;
      end else begin
        rx_q    <= sat_inc(rx_q, rx_inc);
        drop_q  <= sat_inc(drop_q, drop_inc);
        trunc_q <= sat_inc(trunc_q, trunc_inc);
      end
    end
  end

  // Beat storage write port.
  // NOTE: the memory has no reset; empty slots are never presented because the head is masked by out_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_beat;
  end

endmodule

// File: tb/tb_ingress_packet_buffer.sv
// Self-checking bench for ingress_packet_buffer: randomized and directed
// packet traffic, a packet-level reference model and an output scoreboard.
module tb_ingress_packet_buffer;

  localparam int DEPTH = 64;
  localparam int DW    = 512;
  localparam int MAXB  = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_err;
  logic          out_ready;
  logic          stats_clear;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] high_water;
  logic [31:0]   rx_packets;
  logic [31:0]   dropped_packets;
  logic [31:0]   trunc_packets;

  ingress_packet_buffer #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .MAX_PKT_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_err(out_err),
    .out_ready(out_ready), .stats_clear(stats_clear),
    .occupancy(occupancy), .high_water(high_water),
    .rx_packets(rx_packets), .dropped_packets(dropped_packets), .trunc_packets(trunc_packets)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  typedef logic [DW+1:0] exp_beat_t;   // {err, last, data}
  exp_beat_t exp_q[$];

  int          m_occ, m_hw, m_k, m_occ_next;
  bit          m_in_pkt, m_admit, m_wr, m_rd, m_err, m_last;
  int unsigned m_rx, m_drop, m_trunc;
  bit          ev_rx, ev_drop, ev_trunc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_occ = 0; m_hw = 0; m_k = 0;
      m_in_pkt = 0; m_admit = 0;
      m_rx = 0; m_drop = 0; m_trunc = 0;
    end else begin
      m_rd = (m_occ != 0) && out_ready;
      m_wr = 0; ev_rx = 0; ev_drop = 0; ev_trunc = 0;
      if (in_valid && enable) begin
        if (!m_in_pkt) begin
          m_admit = (DEPTH - m_occ) >= MAXB;
          m_k     = 0;
        end
        m_k++;
        if (m_admit && m_k <= MAXB) begin
          m_last = in_last || (m_k == MAXB);
          m_err  = (m_k == MAXB) && !in_last;
          exp_q.push_back({m_err, m_last, in_data});
          m_wr     = 1;
          ev_rx    = m_last;
          ev_trunc = m_err;
        end
        if (!m_admit && in_last) ev_drop = 1;
        m_in_pkt = !in_last;
      end
      m_occ_next = m_occ + int'(m_wr) - int'(m_rd);
      if (stats_clear) begin
        m_rx = 0; m_drop = 0; m_trunc = 0;
        m_hw = m_occ;
      end else begin
        m_rx    += int'(ev_rx);
        m_drop  += int'(ev_drop);
        m_trunc += int'(ev_trunc);
        if (m_occ_next > m_hw) m_hw = m_occ_next;
      end
      m_occ = m_occ_next;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit        stalled;
  exp_beat_t held;
  exp_beat_t got, want;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      got = {out_err, out_last, out_data};
      check("out_valid", out_valid, m_occ != 0);
      check("in_ready", in_ready, enable);
      check("occupancy", occupancy, m_occ);
      check("high_water", high_water, m_hw);
      check("rx_packets", rx_packets, m_rx);
      check("dropped_packets", dropped_packets, m_drop);
      check("trunc_packets", trunc_packets, m_trunc);
      if (stalled && out_valid) begin
        n_checks++;
        if (got !== held) begin
          n_errors++;
          $display("FAIL head_stable: got %h expected %h", got, held);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL beat_unexpected: got %h expected none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_errors++;
            $display("FAIL beat_data: got %h expected %h", got, want);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held    = got;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rand_ready = 0;

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Offer one beat until an enabled cycle accepts it.
  task automatic send_beat(input logic last, input int en_pct);
    bit sent = 0;
    in_valid = 1'b1;
    in_data  = rand_beat();
    in_last  = last;
    for (int t = 0; t < 64 && !sent; t++) begin
      enable = (t >= 32) || ($urandom_range(0, 99) < en_pct);
      sent   = enable;
      tick();
    end
    enable = 1'b1;
  endtask

  task automatic send_pkt(input int n, input int en_pct);
    for (int i = 0; i < n; i++) send_beat(i == n - 1, en_pct);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 500 && m_occ != 0; t++) tick();
    check("drain_occupancy", occupancy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; stats_clear = 1'b0;
    #23;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data[63:0], 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_err", out_err, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_rx", rx_packets, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single 3-beat packet with a ready sink: one cycle of latency.
    in_valid = 1'b1; in_data = rand_beat(); in_last = 1'b0;
    check("empty_before_first", out_valid, 0);
    tick();
    check("first_latency", out_valid, 1);
    send_beat(1'b0, 100);
    send_beat(1'b1, 100);
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    check("t1_rx", rx_packets, 1);
    check("t1_occ", occupancy, 0);

    // Fill: four max packets admitted, fifth dropped.
    out_ready = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(MAXB, 100);
    check("fill_occ", occupancy, DEPTH);
    check("fill_hw", high_water, DEPTH);
    check("fill_rx", rx_packets, 5);
    send_pkt(MAXB, 100);
    check("fill_in_ready", in_ready, 1);
    check("fill_dropped", dropped_packets, 1);
    check("fill_occ_after_drop", occupancy, DEPTH);
    drain();

    // Oversize packet truncated at MAXB beats.
    out_ready = 1'b0;
    send_pkt(MAXB + 4, 100);
    check("trunc_occ", occupancy, MAXB);
    check("trunc_count", trunc_packets, 1);
    check("trunc_rx", rx_packets, 6);
    drain();

    // Full-rate streaming across pointer wrap; occupancy pinned at 1.
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1; in_data = rand_beat(); in_last = (i % 4 == 3);
      tick();
      check("stream_occ", occupancy, 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    drain();
    check("stream_rx", rx_packets, 56);

    // Asynchronous reset during beat 5 of an 8-beat packet.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(1'b0, 100);
    in_valid = 1'b1; in_data = rand_beat(); in_last = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_hw", high_water, 0);
    check("rst_rx", rx_packets, 0);
    check("rst_dropped", dropped_packets, 0);
    check("rst_trunc", trunc_packets, 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_pkt(3, 100);
    check("post_rst_rx", rx_packets, 1);
    check("post_rst_occ", occupancy, 3);
    drain();

    // stats_clear coinciding with a final beat: the clear wins.
    send_beat(1'b0, 100);
    in_valid = 1'b1; in_data = rand_beat(); in_last = 1'b1; stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("clear_rx", rx_packets, 0);

    // enable dropped mid-packet: in_ready low, packet resumes intact.
    send_beat(1'b0, 100);
    send_beat(1'b0, 100);
    in_valid = 1'b1; in_data = rand_beat(); in_last = 1'b0; enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_in_ready", in_ready, 0);
    end
    enable = 1'b1;
    tick();
    send_beat(1'b1, 100);
    in_valid = 1'b0; in_last = 1'b0;
    drain();
    check("enable_rx", rx_packets, 1);

    // Randomized traffic: lengths, gaps, enable, backpressure, clears.
    rand_ready = 1;
    for (int p = 0; p < 60; p++) begin
      send_pkt($urandom_range(1, MAXB + 5), 75);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        stats_clear = ($urandom_range(0, 19) == 0);
        tick();
        stats_clear = 1'b0;
      end
    end
    rand_ready = 0;
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
